// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared states, BCD digit constants and num field positions for service_2_countdown
package countdown_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READY,
        ST_RUN,
        ST_PAUSE,
        ST_ALARM,
        ST_DONE
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] BCD_FIVE = 4'd5;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    localparam int SEC_ONES = 0;
    localparam int SEC_TENS = 4;
    localparam int MIN_ONES = 8;
    localparam int MIN_TENS = 12;

endpackage

// File: rtl/sec_tick_gen.sv
// rtl/sec_tick_gen.sv - prescaler emitting a one-cycle tick every TICK_DIV enabled cycles
module sec_tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/service_2_countdown.sv
// rtl/service_2_countdown.sv - BCD mm:ss countdown with pause and alarm; COUNTDOWN_BLINK_EN blinks sel in ALARM
module service_2_countdown #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int BLINK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        finish1,
    input  logic [15:0] num_in,
    input  logic        push_c,
    output logic [15:0] num,
    output logic [3:0]  sel,
    output logic        alarm,
    output logic        finish2
);

    import countdown_pkg::*;

    state_t      state;
    state_t      state_nx;
    logic [15:0] num_nx;
    logic [15:0] dec;
    logic        push_prev;
    logic        push_ev;
    logic        run_clr;
    logic        tick_en;
    logic        tick;
    logic [3:0]  alarm_sel;

    assign push_ev = push_c && !push_prev;
    // A pause request on a tick cycle freezes the prescaler instead of decrementing.
    assign tick_en = (state == ST_RUN) && !push_ev;

    sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .clr    (run_clr),
        .en     (tick_en),
        .tick   (tick)
    );

    always_comb begin
        dec = num;
        if (num[SEC_ONES +: 4] != BCD_ZERO) begin
            dec[SEC_ONES +: 4] = num[SEC_ONES +: 4] - 4'd1;
        end else begin
            dec[SEC_ONES +: 4] = BCD_NINE;
            if (num[SEC_TENS +: 4] != BCD_ZERO) begin
                dec[SEC_TENS +: 4] = num[SEC_TENS +: 4] - 4'd1;
            end else begin
                dec[SEC_TENS +: 4] = BCD_FIVE;
                if (num[MIN_ONES +: 4] != BCD_ZERO) begin
                    dec[MIN_ONES +: 4] = num[MIN_ONES +: 4] - 4'd1;
                end else begin
                    dec[MIN_ONES +: 4] = BCD_NINE;
                    dec[MIN_TENS +: 4] = num[MIN_TENS +: 4] - 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        num_nx   = num;
        run_clr  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (finish1) begin
                    num_nx   = num_in;
                    state_nx = ST_READY;
                end
            end
            ST_READY, ST_PAUSE: begin
                if (push_ev) begin
                    if (num == 16'h0000) begin
                        state_nx = ST_ALARM;
                    end else begin
                        state_nx = ST_RUN;
                        run_clr  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (push_ev) begin
                    state_nx = ST_PAUSE;
                end else if (tick) begin
                    num_nx = dec;
                    if (dec == 16'h0000) state_nx = ST_ALARM;
                end
            end
            ST_ALARM: begin
                if (push_ev) state_nx = ST_DONE;
            end
            ST_DONE: ;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            num       <= 16'h0000;
            push_prev <= 1'b0;
        end else begin
            state     <= state_nx;
            num       <= num_nx;
            push_prev <= push_c;
        end
    end

`ifdef COUNTDOWN_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_off;

    // Held clear outside ALARM so every entry starts lit with a full half-period.
    always_ff @(posedge clk) begin
        if (!resetn || state != ST_ALARM || state_nx != ST_ALARM) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_off <= !blink_off;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign alarm_sel = blink_off ? 4'b0000 : 4'b1111;
`else
    assign alarm_sel = {4{BLINK_DIV >= 1}};
`endif

    always_comb begin
        case (state)
            ST_IDLE:  sel = 4'b0000;
            ST_ALARM: sel = alarm_sel;
            default:  sel = 4'b1111;
        endcase
    end

    assign alarm   = (state == ST_ALARM);
    assign finish2 = (state == ST_DONE);

endmodule

// File: tb/tb_service_2_countdown.sv
// tb/tb_service_2_countdown.sv - vector-table and scoreboard bench for service_2_countdown
module tb_service_2_countdown;

    localparam int TICK_DIV  = 4;
    localparam int BLINK_DIV = 2;
    localparam logic [3:0] F = 4'hF;

    typedef struct {
        logic        rstn;
        logic        f1;
        logic [15:0] nin;
        logic        pc;
        logic [15:0] e_num;
        logic [3:0]  e_sel;
        logic        e_alarm;
        logic        e_fin;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        finish1;
    logic [15:0] num_in;
    logic        push_c;
    logic [15:0] num;
    logic [3:0]  sel;
    logic        alarm;
    logic        finish2;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs[$];
    vec_t sb[$];

    service_2_countdown #(.TICK_DIV(TICK_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .finish1 (finish1),
        .num_in  (num_in),
        .push_c  (push_c),
        .num     (num),
        .sel     (sel),
        .alarm   (alarm),
        .finish2 (finish2)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bcd(input int s);
        int m;
        int x;
        m = s / 60;
        x = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic logic [3:0] asel(input int i);
`ifdef COUNTDOWN_BLINK_EN
        return (((i / BLINK_DIV) % 2) != 0) ? 4'h0 : 4'hF;
`else
        return (i >= 0) ? 4'hF : 4'hF;
`endif
    endfunction

    task automatic add(input int n, input logic rstn, input logic f1, input logic [15:0] nin,
                       input logic pc, input logic [15:0] en, input logic [3:0] es,
                       input logic ea, input logic ef);
        vec_t v;
        v.rstn = rstn; v.f1 = f1; v.nin = nin; v.pc = pc;
        v.e_num = en; v.e_sel = es; v.e_alarm = ea; v.e_fin = ef;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        add(2, 0, 0, 16'h0000, 0, 16'h0000, 4'h0, 0, 0);

        // 00:12 countdown to alarm; num_in changes after load must be ignored
        add(1, 1, 1, 16'h0012, 0, 16'h0012, F, 0, 0);
        add(1, 1, 1, 16'h5555, 1, 16'h0012, F, 0, 0);
        for (int s = 11; s >= 1; s--) begin
            add(3, 1, 1, 16'h5555, 0, bcd(s + 1), F, 0, 0);
            add(1, 1, 1, 16'h5555, 0, bcd(s), F, 0, 0);
        end
        add(3, 1, 1, 16'h5555, 0, 16'h0001, F, 0, 0);
        for (int i = 0; i < 5; i++) add(1, 1, 1, 16'h5555, 0, 16'h0000, asel(i), 1, 0);
        add(1, 1, 1, 16'h5555, 1, 16'h0000, F, 0, 1);
        add(2, 1, 1, 16'h5555, 0, 16'h0000, F, 0, 1);
        add(1, 1, 1, 16'h5555, 1, 16'h0000, F, 0, 1);
        add(2, 1, 1, 16'h5555, 0, 16'h0000, F, 0, 1);

        // 10:00 borrow chain, then pause on a tick cycle and resume
        add(1, 0, 1, 16'h1000, 0, 16'h0000, 4'h0, 0, 0);
        add(1, 1, 1, 16'h1000, 0, 16'h1000, F, 0, 0);
        add(1, 1, 1, 16'h1000, 1, 16'h1000, F, 0, 0);
        add(3, 1, 1, 16'h1000, 0, 16'h1000, F, 0, 0);
        add(1, 1, 1, 16'h1000, 0, 16'h0959, F, 0, 0);
        add(3, 1, 1, 16'h1000, 0, 16'h0959, F, 0, 0);
        add(1, 1, 1, 16'h1000, 0, 16'h0958, F, 0, 0);
        add(3, 1, 1, 16'h1000, 0, 16'h0958, F, 0, 0);
        add(1, 1, 1, 16'h1000, 1, 16'h0958, F, 0, 0);
        add(6, 1, 1, 16'h1000, 0, 16'h0958, F, 0, 0);
        add(1, 1, 1, 16'h1000, 1, 16'h0958, F, 0, 0);
        add(3, 1, 1, 16'h1000, 0, 16'h0958, F, 0, 0);
        add(1, 1, 1, 16'h1000, 0, 16'h0957, F, 0, 0);

        // reset mid-run at 00:05, reload with finish1 still high, no residual tick
        add(1, 0, 1, 16'h0006, 0, 16'h0000, 4'h0, 0, 0);
        add(1, 1, 1, 16'h0006, 0, 16'h0006, F, 0, 0);
        add(1, 1, 1, 16'h0006, 1, 16'h0006, F, 0, 0);
        add(3, 1, 1, 16'h0006, 0, 16'h0006, F, 0, 0);
        add(1, 1, 1, 16'h0006, 0, 16'h0005, F, 0, 0);
        add(2, 1, 1, 16'h0006, 0, 16'h0005, F, 0, 0);
        add(1, 0, 1, 16'h0006, 0, 16'h0000, 4'h0, 0, 0);
        add(1, 1, 1, 16'h0006, 0, 16'h0006, F, 0, 0);
        add(5, 1, 1, 16'h0006, 0, 16'h0006, F, 0, 0);

        // 00:00 start goes straight to alarm; held acknowledge counts once
        add(1, 0, 1, 16'h0000, 0, 16'h0000, 4'h0, 0, 0);
        add(1, 1, 1, 16'h0000, 0, 16'h0000, F, 0, 0);
        add(1, 1, 1, 16'h0000, 1, 16'h0000, asel(0), 1, 0);
        for (int i = 1; i < 4; i++) add(1, 1, 1, 16'h0000, 0, 16'h0000, asel(i), 1, 0);
        add(10, 1, 1, 16'h0000, 1, 16'h0000, F, 0, 1);
        add(2, 1, 1, 16'h0000, 0, 16'h0000, F, 0, 1);

        // 00:90 unnormalised tens; start button held 10 cycles must not pause
        add(1, 0, 1, 16'h0090, 0, 16'h0000, 4'h0, 0, 0);
        add(1, 1, 1, 16'h0090, 0, 16'h0090, F, 0, 0);
        add(4, 1, 1, 16'h0090, 1, 16'h0090, F, 0, 0);
        add(1, 1, 1, 16'h0090, 1, 16'h0089, F, 0, 0);
        add(3, 1, 1, 16'h0090, 1, 16'h0089, F, 0, 0);
        add(2, 1, 1, 16'h0090, 1, 16'h0088, F, 0, 0);
        add(2, 1, 1, 16'h0090, 0, 16'h0088, F, 0, 0);
        add(1, 1, 1, 16'h0090, 0, 16'h0087, F, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            vec_t e;
            v = vecs[i];
            resetn  = v.rstn;
            finish1 = v.f1;
            num_in  = v.nin;
            push_c  = v.pc;
            sb.push_back(v);
            @(posedge clk);
            @(negedge clk);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard vec %0d: got empty queue expected an entry", i);
            end else begin
                e = sb.pop_front();
                check("num", i, num, e.e_num);
                check("sel", i, {12'h0, sel}, {12'h0, e.e_sel});
                check("alarm", i, {15'h0, alarm}, {15'h0, e.e_alarm});
                check("finish2", i, {15'h0, finish2}, {15'h0, e.e_fin});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
